// File: rtl/pe_feeder_pkg.sv
// Shared types and sizing helpers for the border-PE feeder.
// State encoding plus run-length and magnitude-limit helpers.
package pe_feeder_pkg;

   localparam int DEF_IWIDTH = 8;
   localparam int DEF_KWIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Number of bitstream cycles spent accumulating one term.
   function automatic int run_len(input int cwidth);
      return 2 ** cwidth;
   endfunction

   // Largest weight magnitude the PE can represent.
   function automatic int mag_max(input int iwidth);
      return (2 ** (iwidth - 1)) - 1;
   endfunction

endpackage

// File: rtl/pe_feeder_border_if.sv
// Job/operand handshakes and PE control/data bundle for the border feeder.
// slave = feeder side, master = job source and PE side.
interface pe_feeder_border_if #(
   parameter int IWIDTH = 8,
   parameter int KWIDTH = 8
);
   logic              job_valid;
   logic              job_ready;
   logic [KWIDTH-1:0] job_len;
   logic              op_valid;
   logic              op_ready;
   logic [IWIDTH-1:0] op_ifm;
   logic [IWIDTH-1:0] op_wght;
   logic              busy;
   logic              en_i;
   logic              clr_i;
   logic              en_w;
   logic              clr_w;
   logic              en_o;
   logic              clr_o;
   logic              mac_done;
   logic [IWIDTH-1:0] ifm;
   logic              wght_sign;
   logic [IWIDTH-2:0] wght_abs;

   modport master (
      output job_valid, job_len, op_valid, op_ifm, op_wght,
      input  job_ready, op_ready, busy, en_i, clr_i, en_w, clr_w,
             en_o, clr_o, mac_done, ifm, wght_sign, wght_abs
   );

   modport slave (
      input  job_valid, job_len, op_valid, op_ifm, op_wght,
      output job_ready, op_ready, busy, en_i, clr_i, en_w, clr_w,
             en_o, clr_o, mac_done, ifm, wght_sign, wght_abs
   );
endinterface

// File: rtl/sm_conv.sv
// Two's-complement to sign-magnitude converter; the most negative input
// saturates to the largest representable magnitude.
module sm_conv
   import pe_feeder_pkg::*;
#(
   parameter int IWIDTH = DEF_IWIDTH
) (
   input  logic [IWIDTH-1:0] val_i,
   output logic              sign_o,
   output logic [IWIDTH-2:0] mag_o
);
   localparam logic [IWIDTH-2:0] MAG_LIMIT = (IWIDTH-1)'(mag_max(IWIDTH));

   logic [IWIDTH-1:0] neg_val;

   assign neg_val = ~val_i + IWIDTH'(1);

   always_comb begin
      sign_o = val_i[IWIDTH-1];
      mag_o  = val_i[IWIDTH-2:0];
      if (sign_o) begin
         // Negating the minimum value leaves the MSB set: clamp it.
         if (neg_val[IWIDTH-1]) begin
            mag_o = MAG_LIMIT;
         end else begin
            mag_o = neg_val[IWIDTH-2:0];
         end
      end
   end
endmodule

// File: rtl/pe_feeder_border.sv
// Sequencer feeding the west/north edge of a border PE: per term it loads
// operands, runs the unary bitstream, and signals mac_done after the last term.
module pe_feeder_border
   import pe_feeder_pkg::*;
#(
   parameter int IWIDTH = DEF_IWIDTH,
   parameter int KWIDTH = DEF_KWIDTH,
   parameter int CWIDTH = IWIDTH - 1
) (
   input logic clk,
   input logic rst,
   pe_feeder_border_if.slave bus
);
   localparam logic [CWIDTH-1:0] RUN_LAST = CWIDTH'(run_len(CWIDTH) - 1);

   state_t            state_q, state_d;
   logic [KWIDTH-1:0] term_rem_q, term_rem_d;
   logic              first_q, first_d;
   logic [CWIDTH-1:0] run_cnt_q, run_cnt_d;
   logic [IWIDTH-1:0] ifm_q, ifm_d;
   logic              wght_sign_q, wght_sign_d;
   logic [IWIDTH-2:0] wght_abs_q, wght_abs_d;

   logic              conv_sign;
   logic [IWIDTH-2:0] conv_mag;

   sm_conv #(.IWIDTH(IWIDTH)) u_wght_conv (
      .val_i  (bus.op_wght),
      .sign_o (conv_sign),
      .mag_o  (conv_mag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         term_rem_q  <= '0;
         first_q     <= 1'b0;
         run_cnt_q   <= '0;
         ifm_q       <= '0;
         wght_sign_q <= 1'b0;
         wght_abs_q  <= '0;
      end else begin
         state_q     <= state_d;
         term_rem_q  <= term_rem_d;
         first_q     <= first_d;
         run_cnt_q   <= run_cnt_d;
         ifm_q       <= ifm_d;
         wght_sign_q <= wght_sign_d;
         wght_abs_q  <= wght_abs_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      term_rem_d  = term_rem_q;
      first_d     = first_q;
      run_cnt_d   = run_cnt_q;
      ifm_d       = ifm_q;
      wght_sign_d = wght_sign_q;
      wght_abs_d  = wght_abs_q;
      unique case (state_q)
         IDLE: begin
            if (bus.job_valid) begin
               term_rem_d = bus.job_len;
               first_d    = 1'b1;
               state_d    = (bus.job_len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (bus.op_valid) begin
               ifm_d       = bus.op_ifm;
               wght_sign_d = conv_sign;
               wght_abs_d  = conv_mag;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            first_d   = 1'b0;
            run_cnt_d = '0;
            state_d   = RUN;
         end
         RUN: begin
            run_cnt_d = run_cnt_q + CWIDTH'(1);
            if (run_cnt_q == RUN_LAST) begin
               term_rem_d = term_rem_q - KWIDTH'(1);
               state_d    = (term_rem_q == KWIDTH'(1)) ? DONE : FETCH;
            end
         end
         DONE: begin
            first_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // first_q survives into DONE only when no term was loaded (zero-length job).
   always_comb begin
      bus.job_ready = (state_q == IDLE);
      bus.op_ready  = (state_q == FETCH);
      bus.busy      = (state_q != IDLE);
      bus.en_i      = (state_q == LOAD);
      bus.en_w      = (state_q == LOAD);
      bus.en_o      = (state_q == RUN);
      bus.clr_i     = (state_q == DONE);
      bus.clr_w     = (state_q == DONE);
      bus.mac_done  = (state_q == DONE);
      bus.clr_o     = ((state_q == LOAD) || (state_q == DONE)) && first_q;
   end

   assign bus.ifm       = ifm_q;
   assign bus.wght_sign = wght_sign_q;
   assign bus.wght_abs  = wght_abs_q;

endmodule

// File: doc/pe_feeder_border.md
Name: pe_feeder_border

Overview:
Sequencer that drives the west/north edge of a border PE in the 8-bit unary-rate systolic array. It accepts MAC jobs and per-term (ifm, weight) operand pairs through valid/ready handshakes. It emits the en/clr/mac_done control protocol and operand data the border PE consumes. For each term it loads ifm and sign-magnitude weight, runs the unary bitstream for 2^(IWIDTH-1) cycles with accumulation enabled, and pulses mac_done after the last term.

Parameters:
IWIDTH, 8, operand width (signed two's complement in, sign + (IWIDTH-1)-bit magnitude out)
KWIDTH, 8, width of job term count
CWIDTH, IWIDTH-1, bitstream cycle counter width; RUN length = 2^CWIDTH cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_len  in  KWIDTH  number of MAC terms in job (0 allowed)
op_valid  in  1  operand pair valid
op_ready  out  1  high only in FETCH
op_ifm  in  IWIDTH  signed activation
op_wght  in  IWIDTH  signed weight
busy  out  1  state != IDLE
en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done  out  1 each  PE control
ifm  out  IWIDTH  signed activation to PE
wght_sign  out  1  weight sign
wght_abs  out  IWIDTH-1  weight magnitude

Behaviour:
- One clock, clk. Reset is synchronous and active-high. On rst: state=IDLE; all control outputs, ifm, wght_sign, wght_abs, busy, op_ready = 0; counters = 0; job_ready=1 on the cycle after reset.
- Reset mid-operation: next cycle IDLE, all outputs as reset. No mac_done is issued. The partial job is discarded.
- States: IDLE, FETCH, LOAD, RUN, DONE. Control outputs are Moore decodes of the registered state and registered flags, so they are glitch-free.
- IDLE: job_ready=1. On job_valid, latch job_len into term_rem and set first=1.
  - job_len==0 -> DONE.
  - Otherwise -> FETCH.
- FETCH: op_ready=1. On op_valid, register the operands and convert the weight:
  - ifm <= op_ifm; wght_sign <= op_wght[MSB].
  - wght_abs <= |op_wght|, saturated to 2^(IWIDTH-1)-1, so -128 -> 127 for IWIDTH=8.
  - Then go to LOAD.
  - Without op_valid, stay in FETCH with en_o=0. The accumulator holds, which is a legal stall.
- LOAD: exactly 1 cycle. en_i=1, en_w=1. clr_o=1 iff first; first is cleared on exit. -> RUN with run_cnt=0.
- RUN: en_o=1 every cycle; run_cnt increments. Exit when run_cnt == 2^CWIDTH-1, giving exactly 2^CWIDTH cycles, and decrement term_rem.
  - term_rem (after decrement) > 0 -> FETCH.
  - Otherwise -> DONE.
- DONE: exactly 1 cycle. mac_done=1, clr_i=1, clr_w=1, en_o=0. For a zero-length job clr_o=1 as well, so the PE reports a zero sum. -> IDLE.
- Latency for an N-term job with no stalls: job accept at t0, FETCH at t0+1 with op accepted same cycle. Each term takes 2^CWIDTH+2 cycles (FETCH+LOAD+RUN). mac_done at t0+1+N*(2^CWIDTH+2). For IWIDTH=8, N=1: t0+131.
- Handshakes: a transfer occurs on valid&&ready. job_ready and op_ready never depend combinationally on the valid inputs. ifm, wght_sign and wght_abs are held stable outside FETCH-accept cycles.
- A new job is accepted only in IDLE. The cycle after DONE returns job_ready=1, so back-to-back jobs have a 1-cycle IDLE gap.
- Never assert en_i/en_w together with clr_i/clr_w.
- Never assert en_o in LOAD, FETCH or DONE.

Decomposition:
- Shared package pe_feeder_pkg: state_t enum (IDLE, FETCH, LOAD, RUN, DONE), and the RUN_LEN = 2^CWIDTH and MAG_MAX = 2^(IWIDTH-1)-1 localparam helpers.
- One sub-module, sm_conv: combinational two's-complement to sign-magnitude converter with saturation, also reusable by the ifm-side register path.

Test Plan:
- Reset then single job, job_len=1, op_ifm=5, op_wght=-3:
  - LOAD cycle shows en_i=en_w=clr_o=1, ifm=5, wght_sign=1, wght_abs=3.
  - en_o=1 for exactly 128 cycles.
  - mac_done=1 exactly once, 131 cycles after job accept.
- job_len=2 with op_valid withheld 10 cycles before the second term:
  - FETCH persists 10 cycles with en_o=0 and clr_o=0 on the second LOAD.
  - Total en_o count = 256.
  - mac_done occurs once, 10 cycles later than the no-stall case.
- Saturation: op_wght=-128 -> wght_sign=1, wght_abs=127. op_wght=127 -> wght_sign=0, wght_abs=127. op_wght=0 -> 0/0.
- job_len=0 -> next cycle DONE with mac_done=1, clr_o=1, no en_i/en_w/en_o ever. job_ready=1 the following cycle.
- rst asserted at RUN cycle 50 of a 3-term job:
  - Next cycle all outputs 0, state IDLE, no mac_done.
  - A fresh 1-term job then completes normally in 131 cycles.
- Back-to-back jobs with job_valid held high:
  - The second job is accepted exactly one cycle after the first mac_done.
  - job_ready=0 throughout busy.
